period_meter: RTL and testbench

//  Measures the period of an external slow square wave (e.g. a divided 1 Hz tick or board

---
 rtl/period_meter_if.sv | 26 ++
 rtl/period_meter.sv | 106 ++++++++++
 tb/tb_period_meter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/period_meter_if.sv
// Result port of period_meter: valid/ready handshake plus the result qualifiers.
interface period_meter_if #(
    parameter int unsigned CNT_W = 32
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] period;
    logic             timeout;
    logic             overrun;

    modport master (
        output meas_valid,
        output period,
        output timeout,
        output overrun,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  period,
        input  timeout,
        input  overrun,
        output meas_ready
    );
endinterface

// File: rtl/period_meter.sv
// Period meter: synchronises sig_in, detects rising edges and counts clk cycles
// between consecutive edges. Results leave through a valid/ready port; a
// watchdog reports a timeout result when no edge arrives for TIMEOUT cycles.
module period_meter #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 50000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            sig_in,
    period_meter_if.master  meas,
    output logic            busy
);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    state_t                 state;
    logic                   res_period;
    logic                   res_timeout;
    logic                   new_res;

    // Synchroniser chain and edge history; zero reset keeps the history low.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    // Edge detect and result-producing events for this cycle.
    always_comb begin
        rise        = sync[SYNC_STAGES-1] & ~prev;
        res_period  = (state == COUNT) && rise;
        res_timeout = (state == COUNT) && !rise && (cnt == LAST);
        new_res     = res_period || res_timeout;
    end

    // Measurement FSM with registered result and handshake outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state           <= IDLE;
            cnt             <= '0;
            busy            <= 1'b0;
            meas.meas_valid <= 1'b0;
            meas.period     <= '0;
            meas.timeout    <= 1'b0;
            meas.overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt   <= '0;
                        state <= COUNT;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (res_period) begin
                        cnt          <= '0;
                        meas.period  <= cnt + 1'b1;
                        meas.timeout <= 1'b0;
                    end else if (res_timeout) begin
                        cnt          <= '0;
                        meas.period  <= '0;
                        meas.timeout <= 1'b1;
                        state        <= IDLE;
                        busy         <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A new result always wins; overrun only when the old one was not taken.
            if (new_res) begin
                meas.meas_valid <= 1'b1;
                if (meas.meas_valid && !meas.meas_ready) begin
                    meas.overrun <= 1'b1;
                end else if (meas.meas_valid) begin
                    meas.overrun <= 1'b0;
                end
            end else if (meas.meas_valid && meas.meas_ready) begin
                meas.meas_valid <= 1'b0;
                meas.overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter (CNT_W=16, TIMEOUT=100, SYNC_STAGES=2).
module tb_period_meter;

    localparam int unsigned CW  = 16;
    localparam int unsigned TO  = 100;
    localparam int unsigned SS  = 2;
    localparam int unsigned LAT = SS + 1;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic sig_in = 1'b0;
    logic busy;

    period_meter_if #(.CNT_W(CW)) mif ();

    period_meter #(
        .CNT_W      (CW),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .sig_in(sig_in),
        .meas  (mif),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] period;
        logic        timeout;
    } res_t;

    res_t got[$];

    // Every accepted result, in order.
    always @(negedge clk) begin : mon
        res_t r;
        if (clr_n && mif.meas_valid && mif.meas_ready) begin
            r.period  = 32'(mif.period);
            r.timeout = mif.timeout;
            got.push_back(r);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Rising edge, high for h cycles, low until the next edge gap cycles later.
    task automatic edge_seq(input int gap, input int h);
        sig_in = 1'b1;
        step(h);
        sig_in = 1'b0;
        step(gap - h);
    endtask

    task automatic wait_idle();
        mif.meas_ready = 1'b1;
        sig_in = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy && !mif.meas_valid) break;
            step(1);
        end
        check("idle_busy", {31'd0, busy}, 32'd0);
        step(3);
        got.delete();
    endtask

    task automatic wait_result(input string name);
        for (int i = 0; i < 300; i++) begin
            if (got.size() > 0) break;
            step(1);
        end
        check({name, "_seen"}, {31'd0, got.size() > 0}, 32'd1);
    endtask

    typedef struct {
        int          gap;
        int          h;
        logic [31:0] exp_period;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs[$];
    int   gaps[$];
    res_t expq[$];

    initial begin
        int cnt;
        res_t e;

        vecs.push_back('{20, 10, 32'd20, 1'b0});
        vecs.push_back('{2, 1, 32'd2, 1'b0});
        vecs.push_back('{37, 18, 32'd37, 1'b0});
        vecs.push_back('{3, 1, 32'd3, 1'b0});
        vecs.push_back('{99, 50, 32'd99, 1'b0});
        vecs.push_back('{100, 50, 32'd100, 1'b0});
        vecs.push_back('{101, 50, 32'd0, 1'b1});
        vecs.push_back('{150, 60, 32'd0, 1'b1});

        // Reset state
        mif.meas_ready = 1'b1;
        step(3);
        check("rst_valid", {31'd0, mif.meas_valid}, 32'd0);
        check("rst_period", 32'(mif.period), 32'd0);
        check("rst_timeout", {31'd0, mif.timeout}, 32'd0);
        check("rst_overrun", {31'd0, mif.overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        clr_n = 1'b1;
        step(2);

        // Table: arm edge, second edge gap cycles later, first result checked
        foreach (vecs[k]) begin
            wait_idle();
            edge_seq(vecs[k].gap, vecs[k].h);
            sig_in = 1'b1;
            step(1);
            sig_in = 1'b0;
            wait_result($sformatf("vec%0d", k));
            if (got.size() > 0) begin
                check($sformatf("vec%0d_period", k), got[0].period, vecs[k].exp_period);
                check($sformatf("vec%0d_timeout", k), {31'd0, got[0].timeout}, {31'd0, vecs[k].exp_timeout});
            end
            check($sformatf("vec%0d_overrun", k), {31'd0, mif.overrun}, 32'd0);
        end

        // Dead input: timeout latency and state, then re-arm gives no result
        wait_idle();
        sig_in = 1'b1;
        step(5);
        sig_in = 1'b0;
        cnt = 5;
        while (!mif.meas_valid && cnt < 300) begin
            step(1);
            cnt++;
        end
        check("to_latency", 32'(cnt), 32'(TO + LAT));
        check("to_timeout", {31'd0, mif.timeout}, 32'd1);
        check("to_period", 32'(mif.period), 32'd0);
        check("to_busy", {31'd0, busy}, 32'd0);
        step(1);
        got.delete();
        sig_in = 1'b1;
        step(3);
        sig_in = 1'b0;
        step(20);
        check("rearm_no_result", 32'(got.size()), 32'd0);
        check("rearm_busy", {31'd0, busy}, 32'd1);

        // Consumer stalled across three results
        wait_idle();
        mif.meas_ready = 1'b0;
        edge_seq(20, 10);
        edge_seq(20, 10);
        check("ovr_first_valid", {31'd0, mif.meas_valid}, 32'd1);
        check("ovr_first_overrun", {31'd0, mif.overrun}, 32'd0);
        edge_seq(20, 10);
        check("ovr_second_overrun", {31'd0, mif.overrun}, 32'd1);
        sig_in = 1'b1;
        step(5);
        sig_in = 1'b0;
        check("ovr_valid", {31'd0, mif.meas_valid}, 32'd1);
        check("ovr_period", 32'(mif.period), 32'd20);
        check("ovr_overrun", {31'd0, mif.overrun}, 32'd1);
        mif.meas_ready = 1'b1;
        step(1);
        check("ovr_drain_valid", {31'd0, mif.meas_valid}, 32'd0);
        check("ovr_drain_overrun", {31'd0, mif.overrun}, 32'd0);

        // New result on the same edge as the transfer of the held one
        wait_idle();
        mif.meas_ready = 1'b0;
        edge_seq(20, 10);
        edge_seq(30, 10);
        sig_in = 1'b1;
        step(2);
        check("sim_held_period", 32'(mif.period), 32'd20);
        check("sim_held_overrun", {31'd0, mif.overrun}, 32'd0);
        mif.meas_ready = 1'b1;
        step(1);
        sig_in = 1'b0;
        check("sim_valid", {31'd0, mif.meas_valid}, 32'd1);
        check("sim_period", 32'(mif.period), 32'd30);
        check("sim_overrun", {31'd0, mif.overrun}, 32'd0);
        step(1);
        check("sim_drained", {31'd0, mif.meas_valid}, 32'd0);

        // Asynchronous reset mid-measurement, released with sig_in high
        wait_idle();
        edge_seq(20, 10);
        sig_in = 1'b1;
        step(1);
        sig_in = 1'b0;
        step(50);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #3;
        clr_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, mif.meas_valid}, 32'd0);
        check("arst_period", 32'(mif.period), 32'd0);
        check("arst_timeout", {31'd0, mif.timeout}, 32'd0);
        check("arst_overrun", {31'd0, mif.overrun}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        sig_in = 1'b1;
        step(2);
        #3;
        clr_n = 1'b1;
        got.delete();
        step(30);
        check("post_rst_no_result", 32'(got.size()), 32'd0);
        check("post_rst_valid", {31'd0, mif.meas_valid}, 32'd0);
        sig_in = 1'b0;
        step(10);
        edge_seq(20, 10);
        sig_in = 1'b1;
        step(1);
        sig_in = 1'b0;
        step(5);
        wait_result("post_rst");
        if (got.size() > 0) begin
            check("post_rst_period", got[got.size()-1].period, 32'd20);
            check("post_rst_timeout", {31'd0, got[got.size()-1].timeout}, 32'd0);
        end

        // Random edge trains against a gap-based model
        wait_idle();
        for (int k = 0; k < 60; k++) begin
            int g;
            g = int'($urandom_range(2, 130));
            gaps.push_back(g);
            edge_seq(g, int'($urandom_range(1, g - 1)));
        end
        step(150);
        // Each edge after the first either closes a measurement of its gap
        // or, if the gap exceeded TIMEOUT, follows a timeout and re-arms.
        for (int k = 1; k < 60; k++) begin
            if (gaps[k-1] <= int'(TO)) begin
                e.period  = 32'(gaps[k-1]);
                e.timeout = 1'b0;
            end else begin
                e.period  = 32'd0;
                e.timeout = 1'b1;
            end
            expq.push_back(e);
        end
        e.period  = 32'd0;
        e.timeout = 1'b1;
        expq.push_back(e);
        check("rand_count", 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            check($sformatf("rand%0d_period", i), got[i].period, expq[i].period);
            check($sformatf("rand%0d_timeout", i), {31'd0, got[i].timeout}, {31'd0, expq[i].timeout});
        end
        check("rand_overrun", {31'd0, mif.overrun}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
